// File: rtl/imem_stream_loader.sv
// Run-time loadable instruction memory: zeroed, filled from a big-endian byte
// stream, then serves pipelined word fetches with a fixed response latency.
module imem_stream_loader #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic [IDX_W:0]    load_words,
  output logic              load_ovf,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_instr,
  output logic [1:0]        rsp_fault
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t             state_r, state_n;
  logic               load_ready_r, req_ready_r;
  logic [IDX_W-1:0]   clr_idx_r;
  logic [1:0]         byte_cnt_r;
  logic [31:0]        asm_r;
  logic [IDX_W:0]     load_words_r;
  logic               load_ovf_r;

  logic [31:0]        mem [DEPTH];

  logic               byte_acc_s, full_s, word_done_s, restart_s;
  logic [4:0]         shift_s;
  logic [31:0]        merged_s;
  logic               mem_we_s;
  logic [IDX_W-1:0]   mem_widx_s;
  logic [31:0]        mem_wdata_s;

  logic               fetch_acc_s, mis_s, oob_s;
  logic [ADDR_W-3:0]  fetch_widx_s;
  logic [31:0]        rd_data_s;

  logic               vld_r   [LATENCY];
  logic [31:0]        data_r  [LATENCY];
  logic [1:0]         fault_r [LATENCY];

  // Load-side decode: byte placement, word completion and memory write port.
  always_comb begin
    byte_acc_s  = load_ready_r && load_valid;
    full_s      = (load_words_r == (IDX_W+1)'(DEPTH));
    restart_s   = (state_r == ST_READY) && load_start;
    shift_s     = 5'd24 - {byte_cnt_r, 3'b000};
    merged_s    = asm_r | (32'(load_byte) << shift_s);
    word_done_s = byte_acc_s && !full_s && ((byte_cnt_r == 2'd3) || load_last);
    if (state_r == ST_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = clr_idx_r;
      mem_wdata_s = 32'd0;
    end else begin
      mem_we_s    = word_done_s;
      mem_widx_s  = load_words_r[IDX_W-1:0];
      mem_wdata_s = merged_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_idx_r == IDX_W'(DEPTH - 1)) state_n = ST_LOAD;
        else                                state_n = ST_CLEAR;
      end
      ST_LOAD: begin
        if (byte_acc_s && load_last) state_n = ST_READY;
        else                         state_n = ST_LOAD;
      end
      ST_READY: begin
        if (load_start) state_n = ST_CLEAR;
        else            state_n = ST_READY;
      end
      default: state_n = ST_CLEAR;
    endcase
  end

  // State register; handshake readies are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_CLEAR;
      load_ready_r <= 1'b0;
      req_ready_r  <= 1'b0;
    end else begin
      state_r      <= state_n;
      load_ready_r <= (state_n == ST_LOAD);
      req_ready_r  <= (state_n == ST_READY);
    end
  end

  // Clear pointer, byte assembly and load status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx_r    <= '0;
      byte_cnt_r   <= 2'd0;
      asm_r        <= 32'd0;
      load_words_r <= '0;
      load_ovf_r   <= 1'b0;
    end else if (restart_s) begin
      clr_idx_r    <= '0;
      byte_cnt_r   <= 2'd0;
      asm_r        <= 32'd0;
      load_words_r <= '0;
      load_ovf_r   <= 1'b0;
    end else begin
      if (state_r == ST_CLEAR) clr_idx_r <= clr_idx_r + IDX_W'(1);
      // Once full, further bytes are dropped but keep the stream flowing to load_last.
      if (byte_acc_s) begin
        if (full_s) begin
          load_ovf_r <= 1'b1;
        end else if (word_done_s) begin
          load_words_r <= load_words_r + (IDX_W+1)'(1);
          byte_cnt_r   <= 2'd0;
          asm_r        <= 32'd0;
        end else begin
          byte_cnt_r   <= byte_cnt_r + 2'd1;
          asm_r        <= merged_s;
        end
      end
    end
  end

  // Memory write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem[mem_widx_s] <= mem_wdata_s;
  end

  // Fetch decode; any index bit beyond DEPTH faults instead of aliasing.
  always_comb begin
    fetch_acc_s  = req_valid && req_ready_r;
    fetch_widx_s = req_addr[ADDR_W-1:2];
    mis_s        = |req_addr[1:0];
    oob_s        = (fetch_widx_s >= (ADDR_W-2)'(DEPTH));
    if (mis_s || oob_s) rd_data_s = 32'd0;
    else                rd_data_s = mem[fetch_widx_s[IDX_W-1:0]];
  end

  // Response pipe: data is captured at accept, so a later clear cannot alter it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_r[i]   <= 1'b0;
        data_r[i]  <= 32'd0;
        fault_r[i] <= 2'd0;
      end
    end else begin
      vld_r[0]   <= fetch_acc_s;
      data_r[0]  <= rd_data_s;
      fault_r[0] <= {oob_s, mis_s};
      for (int i = 1; i < LATENCY; i++) begin
        vld_r[i]   <= vld_r[i-1];
        data_r[i]  <= data_r[i-1];
        fault_r[i] <= fault_r[i-1];
      end
    end
  end

  assign load_ready = load_ready_r;
  assign req_ready  = req_ready_r;
  assign load_words = load_words_r;
  assign load_ovf   = load_ovf_r;
  assign rsp_valid  = vld_r[LATENCY-1];
  assign rsp_instr  = data_r[LATENCY-1];
  assign rsp_fault  = fault_r[LATENCY-1];

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader: directed loads and fetches, with a
// monitor checking response data, fault bits and arrival cycle.
module tb_imem_stream_loader;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 32;
  localparam int LATENCY = 3;
  localparam int IDX_W   = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              load_valid = 1'b0;
  logic [7:0]        load_byte = 8'd0;
  logic              load_last = 1'b0;
  logic              load_ready;
  logic [IDX_W:0]    load_words;
  logic              load_ovf;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_instr;
  logic [1:0]        rsp_fault;

  imem_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
    .load_words(load_words), .load_ovf(load_ovf), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_instr(rsp_instr), .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  fault;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_instr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("rsp_instr", 64'(rsp_instr), 64'(e.instr));
        check("rsp_fault", 64'(rsp_fault), 64'(e.fault));
        check("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic l);
    int n = 0;
    load_valid = 1'b1; load_byte = b; load_last = l;
    while (!load_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("load_ready_at_byte", 64'(load_ready), 64'd1);
    @(posedge clk); #1;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic wait_load(input string name);
    int n = 0;
    while (!load_ready && n < 200) begin @(posedge clk); #1; n++; end
    check(name, 64'(n), 64'(DEPTH));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready_after_load", 64'(req_ready), 64'd1);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ef, input logic keep);
    exp_t e;
    req_valid = 1'b1; req_addr = a;
    check("req_ready_at_fetch", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    e.instr = ei; e.fault = ef; e.due = cyc + LATENCY - 1;
    q.push_back(e);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic restart();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check("req_ready_drops", 64'(req_ready), 64'd0);
    check("words_cleared", 64'(load_words), 64'd0);
    wait_load("clear_cycles_restart");
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {rsp_valid, rsp_instr, rsp_fault, load_ready, req_ready, load_words, load_ovf}, 64'd0);
  endtask

  initial begin
    exp_t e;
    int n;
    // 1: reset, full clear, two-word image.
    #2;
    check_outputs_zero("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_load("clear_cycles_reset");
    send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    send(8'h93, 1'b0); send(8'h00, 1'b0); send(8'h10, 1'b0); send(8'h00, 1'b1);
    check("load_words_t1", 64'(load_words), 64'd2);
    wait_ready();
    fetch(32'h0, 32'h1300_0000, 2'b00, 1'b0);
    fetch(32'h4, 32'h9300_1000, 2'b00, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    // 2: request accepted alongside load_start returns pre-clear data; then padded image.
    req_valid = 1'b1; req_addr = 32'h4; load_start = 1'b1;
    @(posedge clk); #1;
    e.instr = 32'h9300_1000; e.fault = 2'b00; e.due = cyc + LATENCY - 1;
    q.push_back(e);
    req_valid = 1'b0; load_start = 1'b0;
    check("req_ready_drops", 64'(req_ready), 64'd0);
    check("words_cleared", 64'(load_words), 64'd0);
    wait_load("clear_cycles_restart");
    send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b0);
    send(8'h01, 1'b1);
    check("load_words_t2", 64'(load_words), 64'd2);
    wait_ready();
    fetch(32'h4, 32'h0100_0000, 2'b00, 1'b0);
    fetch(32'h8, 32'h0000_0000, 2'b00, 1'b0);

    // 3: back-to-back fetches, no bubbles.
    fetch(32'h0, 32'hDEAD_BEEF, 2'b00, 1'b1);
    fetch(32'h4, 32'h0100_0000, 2'b00, 1'b1);
    fetch(32'h0, 32'hDEAD_BEEF, 2'b00, 1'b0);

    // 4: fault encodings, including high address bits.
    fetch(32'h2, 32'h0, 2'b01, 1'b0);
    fetch(32'h40, 32'h0, 2'b10, 1'b0);
    fetch(32'h41, 32'h0, 2'b11, 1'b0);
    fetch(32'h8000_0000, 32'h0, 2'b10, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    // 5: overlong image; excess bytes dropped, ovf sticky.
    restart();
    for (int i = 0; i < 4 * DEPTH + 4; i++) send(8'(i), (i == 4 * DEPTH + 3));
    check("load_words_full", 64'(load_words), 64'(DEPTH));
    check("load_ovf", 64'(load_ovf), 64'd1);
    wait_ready();
    fetch(32'h3C, 32'h3C3D_3E3F, 2'b00, 1'b0);
    fetch(32'h00, 32'h0001_0203, 2'b00, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    // 6: async reset in the middle of a load.
    restart();
    for (int i = 0; i < 6; i++) send(8'h50 + 8'(i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midload_reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_load("clear_cycles_reset");
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b1);
    check("load_words_t6", 64'(load_words), 64'd1);
    check("load_ovf_t6", 64'(load_ovf), 64'd0);
    wait_ready();
    fetch(32'h0, 32'hAABB_CCDD, 2'b00, 1'b0);
    fetch(32'h4, 32'h0000_0000, 2'b00, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
